// File: rtl/mem_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_ctrl_if
// Description : Requester-side bus between the CPU control FSM / datapath and
//               the memory/I-O controller. The master modport is the CPU
//               side, the slave modport is the controller side.
// Signals     : mem_cmd    2       00 none, 01 read, 10 write, 11 illegal
//               mem_addr   ADDR_W  transaction address
//               write_data DATA_W  write data
//               read_data  DATA_W  registered read result
//               mem_ready  1       one-cycle completion pulse
//               bus_err    1       one-cycle error pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              bus_err;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  mem_ready,
        input  bus_err
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output mem_ready,
        output bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_ctrl
// Description : Memory/I-O controller. Latches a read or write command from
//               the CPU, sequences a 1-cycle synchronous-read RAM access or a
//               memory-mapped LED/switch access over WAIT_CYCLES+1 ACCESS
//               cycles, and completes with a one-cycle mem_ready pulse.
// Ports       : clk        in   rising-edge clock
//               rst_n      in   asynchronous active-low reset
//               bus        --   requester bus (slave modport)
//               ram_addr   out  RAM address (low bits of the address)
//               ram_we     out  RAM write enable (first ACCESS cycle only)
//               ram_wdata  out  RAM write data
//               ram_rdata  in   RAM read data, valid 1 cycle after ram_addr
//               sw_in      in   asynchronous switch inputs
//               led_out    out  LED register
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_ctrl #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR     = 9'h140
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mem_io_ctrl_if.slave           bus,
    output logic [ADDR_W-2:0]      ram_addr,
    output logic                   ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    input  wire logic [DATA_W-1:0] ram_rdata,
    input  wire logic [7:0]        sw_in,
    output logic [7:0]             led_out
);

    localparam logic [1:0] c_cmd_read    = 2'b01;
    localparam logic [1:0] c_cmd_write   = 2'b10;
    localparam logic [1:0] c_cmd_illegal = 2'b11;
    localparam logic [3:0] c_wait        = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_illegal;
    logic                w_finish;

    logic [1:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_read_data;
    logic                r_bus_err;
    logic [7:0]          r_led;
    logic [7:0]          r_sw_meta;
    logic [7:0]          r_sw_sync;

    logic                w_is_ram;
    logic                w_is_led;
    logic                w_is_sw;
    logic                w_is_unmapped;
    logic                w_is_write;

    // Decode always works on the latched address and command.
    assign w_is_ram      = (r_addr < LED_ADDR);
    assign w_is_led      = (r_addr == LED_ADDR);
    assign w_is_sw       = (r_addr == SW_ADDR);
    assign w_is_unmapped = !(w_is_ram || w_is_led || w_is_sw);
    assign w_is_write    = (r_cmd == c_cmd_write);

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_illegal    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_cmd == c_cmd_read || bus.mem_cmd == c_cmd_write) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACCESS;
                end else if (bus.mem_cmd == c_cmd_illegal) begin
                    w_illegal    = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd  <= 2'b00;
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= 4'd0;
        end else if (w_accept) begin
            r_cmd  <= bus.mem_cmd;
            r_addr <= bus.mem_addr;
            r_data <= bus.write_data;
            r_cnt  <= c_wait;
        end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Completion: read data capture, LED update and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= '0;
            r_led       <= 8'h00;
            r_bus_err   <= 1'b0;
        end else begin
            // Illegal commands flag in the next cycle; unmapped accesses
            // flag together with mem_ready in the DONE cycle.
            r_bus_err <= w_illegal || (w_finish && w_is_unmapped);
            if (w_finish) begin
                if (w_is_write) begin
                    if (w_is_led) begin
                        r_led <= r_data[7:0];
                    end
                end else begin
                    if (w_is_ram) begin
                        r_read_data <= ram_rdata;
                    end else if (w_is_led) begin
                        r_read_data <= DATA_W'(r_led);
                    end else if (w_is_sw) begin
                        r_read_data <= DATA_W'(r_sw_sync);
                    end else begin
                        r_read_data <= '0;
                    end
                end
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // RAM port
    // ------------------------------------------------------------------
    // The incoming address is presented in the accepting IDLE cycle so the
    // synchronous-read RAM has its data ready inside the first ACCESS cycle;
    // this keeps reads correct even with zero wait states.
    assign ram_addr  = w_accept ? bus.mem_addr[ADDR_W-2:0] : r_addr[ADDR_W-2:0];
    assign ram_wdata = r_data;
    // First ACCESS cycle is the one where the counter still holds its load
    // value; ram_we is purely state-derived so reset removes it at once.
    assign ram_we    = (r_state == ST_ACCESS) && (r_cnt == c_wait) &&
                       w_is_write && w_is_ram;

    assign bus.read_data = r_read_data;
    assign bus.mem_ready = (r_state == ST_DONE);
    assign bus.bus_err   = r_bus_err;
    assign led_out       = r_led;

endmodule
`default_nettype wire
